// File: rtl/instr_sequencer.sv
// Multi-cycle execution sequencer: fetch/exec stepping, load wait and swap
// phases, halt on DONE, and a saturating busy-cycle counter.
module instr_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        load,
    input  logic        do_swap,
    input  logic        done_in,
    input  logic        branch_taken,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_load,
    output logic        wb_en,
    output logic        mem_we,
    output logic [1:0]  swap_phase,
    output logic        busy,
    output logic        halted,
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM_WAIT,
        SWAP_B,
        SWAP_C,
        HALT
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] wait_cnt;
    logic [1:0] wait_nx;

    assign busy   = (state != IDLE) && (state != HALT);
    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 2'd0;
            cycle_count <= 16'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (state == IDLE && start)
                cycle_count <= 16'd0;
            else if (busy && cycle_count != 16'hFFFF)
                cycle_count <= cycle_count + 16'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        wait_nx    = wait_cnt;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        wb_en      = 1'b0;
        mem_we     = 1'b0;
        swap_phase = 2'b00;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = FETCH;
            end
            FETCH: begin
                ir_en    = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                // Priority order: DONE beats SWAP beats LOAD beats plain ops
                if (done_in) begin
                    state_nx = HALT;
                end else if (do_swap) begin
                    swap_phase = 2'b01;
                    state_nx   = SWAP_B;
                end else if (load) begin
                    wait_nx  = WAIT_INIT;
                    state_nx = MEM_WAIT;
                end else begin
                    wb_en    = reg_write;
                    mem_we   = mem_write;
                    pc_en    = 1'b1;
                    pc_load  = branch_taken;
                    state_nx = FETCH;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    wb_en    = 1'b1;
                    pc_en    = 1'b1;
                    state_nx = FETCH;
                end else begin
                    wait_nx = wait_cnt - 2'd1;
                end
            end
            SWAP_B: begin
                swap_phase = 2'b10;
                wb_en      = 1'b1;
                state_nx   = SWAP_C;
            end
            SWAP_C: begin
                swap_phase = 2'b11;
                wb_en      = 1'b1;
                pc_en      = 1'b1;
                state_nx   = FETCH;
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with MEM_LAT=3: directed per-cycle
// vectors push expected outputs; a negedge monitor pops and compares.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        reg_write;
    logic        mem_write;
    logic        load;
    logic        do_swap;
    logic        done_in;
    logic        branch_taken;
    logic        ir_en;
    logic        pc_en;
    logic        pc_load;
    logic        wb_en;
    logic        mem_we;
    logic [1:0]  swap_phase;
    logic        busy;
    logic        halted;
    logic [15:0] cycle_count;

    instr_sequencer #(.MEM_LAT(3)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .reg_write(reg_write),
        .mem_write(mem_write),
        .load(load),
        .do_swap(do_swap),
        .done_in(done_in),
        .branch_taken(branch_taken),
        .ir_en(ir_en),
        .pc_en(pc_en),
        .pc_load(pc_load),
        .wb_en(wb_en),
        .mem_we(mem_we),
        .swap_phase(swap_phase),
        .busy(busy),
        .halted(halted),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [24:0] v;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    // Monitor: compares every output of the cycle against the queued vector
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [24:0] act;
            e   = q.pop_front();
            act = {ir_en, pc_en, pc_load, wb_en, mem_we, swap_phase,
                   busy, halted, cycle_count};
            total++;
            if (act === e.v)
                passed++;
            else
                $display("FAIL %s: got %h expected %h", e.name, act, e.v);
        end
    end

    // in = {reset,start,reg_write,mem_write,load,do_swap,done_in,branch_taken}
    // f  = {ir_en,pc_en,pc_load,wb_en,mem_we,swap_phase[1:0],busy,halted}
    task automatic cyc(input string name, input logic [7:0] in,
                       input logic [8:0] f, input logic [15:0] c,
                       input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        {reset, start, reg_write, mem_write,
         load, do_swap, done_in, branch_taken} = in;
        if (chk) begin
            e.name = name;
            e.v    = {f, c};
            q.push_back(e);
        end
    endtask

    initial begin
        {reset, start, reg_write, mem_write,
         load, do_swap, done_in, branch_taken} = 8'b1000_0000;
        cyc("por",        8'b1000_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b0);
        cyc("reset_idle", 8'b0000_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("idle_start", 8'b0100_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("fetch1",     8'b0100_0000, 9'b1_0_0_0_0_00_1_0, 16'd0,  1'b1);
        cyc("add_exec",   8'b0110_0000, 9'b0_1_0_1_0_00_1_0, 16'd1,  1'b1);
        cyc("fetch2",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd2,  1'b1);
        cyc("br_exec",    8'b0001_0001, 9'b0_1_1_0_1_00_1_0, 16'd3,  1'b1);
        cyc("fetch3",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd4,  1'b1);
        cyc("ld_exec",    8'b0011_1001, 9'b0_0_0_0_0_00_1_0, 16'd5,  1'b1);
        cyc("ld_wait2",   8'b0011_0001, 9'b0_0_0_0_0_00_1_0, 16'd6,  1'b1);
        cyc("ld_wait1",   8'b0011_0001, 9'b0_0_0_0_0_00_1_0, 16'd7,  1'b1);
        cyc("ld_wait0",   8'b0000_0001, 9'b0_1_0_1_0_00_1_0, 16'd8,  1'b1);
        cyc("fetch4",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd9,  1'b1);
        cyc("sw_exec",    8'b0010_0101, 9'b0_0_0_0_0_01_1_0, 16'd10, 1'b1);
        cyc("sw_b",       8'b0000_0001, 9'b0_0_0_1_0_10_1_0, 16'd11, 1'b1);
        cyc("sw_c",       8'b0000_0001, 9'b0_1_0_1_0_11_1_0, 16'd12, 1'b1);
        cyc("fetch5",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd13, 1'b1);
        cyc("done_exec",  8'b0010_0110, 9'b0_0_0_0_0_00_1_0, 16'd14, 1'b1);
        cyc("halt_start", 8'b0100_0000, 9'b0_0_0_0_0_00_0_1, 16'd15, 1'b1);
        cyc("halt_idle",  8'b0000_0000, 9'b0_0_0_0_0_00_0_1, 16'd15, 1'b1);
        cyc("halt_start2",8'b0100_0000, 9'b0_0_0_0_0_00_0_1, 16'd15, 1'b1);
        cyc("halt_rst",   8'b1000_0000, 9'b0_0_0_0_0_00_0_1, 16'd15, 1'b1);
        cyc("post_halt",  8'b0000_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("start2",     8'b0100_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("fetch6",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd0,  1'b1);
        cyc("sw2_exec",   8'b0000_0100, 9'b0_0_0_0_0_01_1_0, 16'd1,  1'b1);
        cyc("sw2_b_rst",  8'b1000_0000, 9'b0_0_0_1_0_10_1_0, 16'd2,  1'b1);
        cyc("abort_idle", 8'b0000_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("no_swap_c",  8'b0000_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("start3",     8'b0100_0000, 9'b0_0_0_0_0_00_0_0, 16'd0,  1'b1);
        cyc("fetch7",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd0,  1'b1);
        cyc("add2_exec",  8'b0010_0000, 9'b0_1_0_1_0_00_1_0, 16'd1,  1'b1);
        cyc("fetch8",     8'b0000_0000, 9'b1_0_0_0_0_00_1_0, 16'd2,  1'b1);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
